// File: rtl/uart_ram_arbiter.sv
// uart_ram_arbiter: shares the servant_ram Wishbone port between the SERV CPU and a
// UART RX byte-DMA that writes received bytes into a circular RAM ring.
// Optional feature macro: UART_RAM_ARB_STATUS_EN (internal status/clear register).

// Purpose: small byte FIFO buffering received UART bytes for the DMA writer.
// Latency: a pushed byte is visible at head the cycle after the push.
// Backpressure: none internally; the caller only pushes when not full or when popping.
module uart_ram_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [4:0]       cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // Pointer and occupancy bookkeeping; index wrap relies on DEPTH being a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= 5'd0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_idx <= rd_idx + 1'b1;
      if (push && !pop)      cnt <= cnt + 5'd1;
      else if (pop && !push) cnt <= cnt - 5'd1;
    end
  end

  // Storage is not reset; clearing the pointers is what discards stale bytes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_dat;
  end

  assign head = mem[rd_idx];
endmodule

// Purpose: round-robin Wishbone arbiter, CPU vs RX byte-DMA into ring [ADR_LL, ADR_UL).
// Latency: grant registered 1 cycle after request; CPU ack follows RAM ack combinationally.
// Backpressure: RX bytes are dropped (sticky o_overflow) when the FIFO is full and not popping.
module uart_ram_arbiter #(
  parameter logic [31:0] ADR_LL     = 32'h00C00000,
  parameter logic [31:0] ADR_UL     = 32'h00C10000,
  parameter int          FIFO_DEPTH = 4
`ifdef UART_RAM_ARB_STATUS_EN
  , parameter logic [31:0] STATUS_ADR = 32'h00C20000
`endif
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic [31:0] i_cpu_adr,
  input  logic [31:0] i_cpu_dat,
  input  logic [3:0]  i_cpu_sel,
  input  logic        i_cpu_we,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic [31:0] o_ram_adr,
  output logic [31:0] o_ram_dat,
  output logic [3:0]  o_ram_sel,
  output logic        o_ram_we,
  output logic        o_ram_cyc,
  input  logic [31:0] i_ram_rdt,
  input  logic        i_ram_ack,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_dat,
  output logic [31:0] o_wr_ptr,
  output logic [4:0]  o_fifo_cnt,
  output logic        o_overflow
);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2,
    STS_ACK = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_dma;
  logic        last_dma_nxt;
  logic        cpu_req;
  logic        dma_req;
  logic        pop;
  logic        push;
  logic        drop;
  logic [7:0]  fifo_head;
  logic [31:0] ptr_inc;

  assign cpu_req = i_cpu_cyc;
  assign dma_req = (o_fifo_cnt != 5'd0);
  // A pop frees a slot in the same cycle, so a push at full is still accepted then.
  assign push    = i_rx_done && ((o_fifo_cnt < DEPTH_C) || pop);
  assign drop    = i_rx_done && !push;
  assign ptr_inc = o_wr_ptr + 32'd1;

`ifdef UART_RAM_ARB_STATUS_EN
  logic sts_hit;
  logic sts_clr;
  assign sts_hit = (i_cpu_adr[31:2] == STATUS_ADR[31:2]);
  assign sts_clr = (state == STS_ACK) && i_cpu_we && i_cpu_sel[3] && i_cpu_dat[31];
`endif

  uart_ram_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk      (i_wb_clk),
    .rst      (i_wb_rst),
    .push     (push),
    .push_dat (i_rx_dat),
    .pop      (pop),
    .head     (fifo_head),
    .cnt      (o_fifo_cnt)
  );

  // Grant state and round-robin history; last_dma resets high so the CPU wins the first tie.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state    <= IDLE;
      last_dma <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_dma <= last_dma_nxt;
    end
  end

  // Arbitration in IDLE and combinational steering of the RAM port for the granted owner.
  always_comb begin
    state_nxt    = state;
    last_dma_nxt = last_dma;
    o_ram_cyc    = 1'b0;
    o_ram_we     = 1'b0;
    o_ram_adr    = 32'h0;
    o_ram_dat    = 32'h0;
    o_ram_sel    = 4'h0;
    o_cpu_ack    = 1'b0;
    o_cpu_rdt    = 32'h0;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && (!dma_req || last_dma)) begin
          last_dma_nxt = 1'b0;
`ifdef UART_RAM_ARB_STATUS_EN
          state_nxt    = sts_hit ? STS_ACK : GNT_CPU;
`else
          state_nxt    = GNT_CPU;
`endif
        end else if (dma_req) begin
          last_dma_nxt = 1'b1;
          state_nxt    = GNT_DMA;
        end
      end
      GNT_CPU: begin
        o_ram_cyc = 1'b1;
        o_ram_we  = i_cpu_we;
        o_ram_adr = i_cpu_adr;
        o_ram_dat = i_cpu_dat;
        o_ram_sel = i_cpu_sel;
        o_cpu_ack = i_ram_ack;
        o_cpu_rdt = i_ram_rdt;
        if (i_ram_ack) state_nxt = IDLE;
      end
      GNT_DMA: begin
        o_ram_cyc = 1'b1;
        o_ram_we  = 1'b1;
        o_ram_adr = o_wr_ptr;
        o_ram_dat = {4{fifo_head}};
        o_ram_sel = 4'b0001 << o_wr_ptr[1:0];
        if (i_ram_ack) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef UART_RAM_ARB_STATUS_EN
      STS_ACK: begin
        o_cpu_ack = 1'b1;
        o_cpu_rdt = {o_overflow, 10'b0, o_fifo_cnt, o_wr_ptr[15:0]};
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Ring write pointer advances once per completed DMA byte and wraps at ADR_UL.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_wr_ptr <= ADR_LL;
    end else if (pop) begin
      o_wr_ptr <= (ptr_inc == ADR_UL) ? ADR_LL : ptr_inc;
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      o_overflow <= 1'b0;
    end else if (drop) begin
      o_overflow <= 1'b1;
`ifdef UART_RAM_ARB_STATUS_EN
    end else if (sts_clr) begin
      o_overflow <= 1'b0;
`endif
    end
  end
endmodule

// File: doc/uart_ram_arbiter.md
Name: uart_ram_arbiter

Overview:
- Shares the single servant_ram Wishbone port between two requesters: the SERV CPU data/instruction master and a byte-DMA writer fed by uart_rx.
- Received BLE bytes are buffered in a small FIFO, then written one byte per transaction into a circular RAM region [ADR_LL, ADR_UL).
- Replaces the ad-hoc per-cycle muxing in the top level. Sits between servant, uart_rx and servant_ram.

Parameters:
- ADR_LL, 32'h00C00000, first byte address of the RX ring region.
- ADR_UL, 32'h00C10000, one past the last byte address of the ring (exclusive).
- FIFO_DEPTH, 4, RX byte FIFO depth; must be a power of 2, 2..16.
- STATUS_ADR, 32'h00C20000, status register address (only with the optional feature).

Ports:
- i_wb_clk  in  1  system clock.
- i_wb_rst  in  1  asynchronous active-high reset.
- i_cpu_adr  in  32  CPU Wishbone address.
- i_cpu_dat  in  32  CPU write data.
- i_cpu_sel  in  4  CPU byte selects.
- i_cpu_we  in  1  CPU write enable.
- i_cpu_cyc  in  1  CPU cycle request.
- o_cpu_rdt  out  32  CPU read data.
- o_cpu_ack  out  1  CPU acknowledge.
- o_ram_adr  out  32  RAM address.
- o_ram_dat  out  32  RAM write data.
- o_ram_sel  out  4  RAM byte selects.
- o_ram_we  out  1  RAM write enable.
- o_ram_cyc  out  1  RAM cycle.
- i_ram_rdt  in  32  RAM read data.
- i_ram_ack  in  1  RAM acknowledge; single-cycle pulse.
- i_rx_done  in  1  one-cycle pulse: new byte valid.
- i_rx_dat  in  8  received byte.
- o_wr_ptr  out  32  next ring byte address to be written.
- o_fifo_cnt  out  5  current FIFO occupancy.
- o_overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset values: state IDLE; o_ram_cyc=0, o_ram_we=0, o_ram_sel=0, o_ram_adr=0, o_ram_dat=0; o_cpu_ack=0, o_cpu_rdt=0; o_wr_ptr=ADR_LL; o_fifo_cnt=0; o_overflow=0; last_grant=DMA, so the CPU wins the first tie.
- Reset mid-transaction: everything returns to the reset values immediately. The FIFO is flushed and any pending RAM cycle is abandoned.
- State machine, states IDLE, GNT_CPU, GNT_DMA:
  - IDLE: cpu_req = i_cpu_cyc; dma_req = (fifo_cnt != 0).
  - Only one request pending: grant it.
  - Both pending: grant the opposite of last_grant (round-robin).
  - The grant is registered. The next cycle enters GNT_*, and last_grant is updated.
  - GNT_CPU: o_ram_* driven combinationally from i_cpu_*; o_cpu_ack = i_ram_ack; o_cpu_rdt = i_ram_rdt. On i_ram_ack, go to IDLE.
  - GNT_DMA: o_ram_cyc=1, o_ram_we=1, o_ram_adr=o_wr_ptr, o_ram_dat={4{fifo_head}}, o_ram_sel=4'b0001<<o_wr_ptr[1:0]. On i_ram_ack: pop the FIFO, advance the pointer, go to IDLE.
  - IDLE drives o_ram_cyc=0 and o_cpu_ack=0.
- CPU latency: i_cpu_cyc asserted in cycle t, grant in t+1, RAM ack (and o_cpu_ack) in t+2.
- The CPU keeps i_cpu_cyc and its address/data stable until o_cpu_ack (Wishbone classic). Behaviour is undefined otherwise.
- Pointer arithmetic: on each DMA ack, o_wr_ptr <= (o_wr_ptr+1 == ADR_UL) ? ADR_LL : o_wr_ptr+1. The pointer is 32-bit unsigned and never leaves [ADR_LL, ADR_UL).
- FIFO push:
  - i_rx_done pushes i_rx_dat if fifo_cnt < FIFO_DEPTH, or if a pop occurs in the same cycle (simultaneous push+pop at full is accepted; count unchanged).
  - Otherwise the byte is dropped and o_overflow <= 1, sticky until reset.
  - Push on empty plus pop is impossible, since a pop requires a non-empty FIFO.
- Starvation bound: each requester waits at most one opposing transaction.

Optional Feature:
- Macro: UART_RAM_ARB_STATUS_EN.
- Defined: CPU accesses with i_cpu_adr[31:2]==STATUS_ADR[31:2] are served internally and never reach the RAM.
  - o_cpu_ack is asserted one cycle after the request in IDLE, with o_ram_cyc held at 0.
  - Read data: {o_overflow, 10'b0, o_fifo_cnt, o_wr_ptr[15:0]}.
  - A write with i_cpu_sel[3]=1 and i_cpu_dat[31]=1 clears o_overflow. A simultaneous overflow event wins (flag stays 1).
- Undefined: STATUS_ADR is an ordinary RAM address routed through GNT_CPU.

Test Plan:
- CPU read only: i_cpu_cyc=1 at t, adr=0x100, RAM returns 0xDEADBEEF → o_ram_cyc=1 at t+1, o_cpu_ack=1 with rdt=0xDEADBEEF at t+2, o_ram_cyc=0 at t+3.
- Single RX byte 0x5A, FIFO empty → one DMA write: adr 0x00C00000, sel 0001, dat 0x5A5A5A5A; then o_wr_ptr=0x00C00001, o_fifo_cnt=0.
- Tie: CPU cyc and a pending DMA both in IDLE after reset → CPU granted first, DMA next. Repeat the tie → the order alternates.
- Wrap: set ADR_UL=ADR_LL+4 and push 5 bytes → writes to +0,+1,+2,+3 with sels 0001/0010/0100/1000, then +0 again; o_wr_ptr ends at ADR_LL+1.
- Overflow: hold the CPU busy and push FIFO_DEPTH+1 bytes → o_fifo_cnt=4, o_overflow=1. The dropped byte is never written; the 4 buffered bytes are written in order.
- Reset mid-DMA: assert i_wb_rst while GNT_DMA → o_ram_cyc=0 in the same cycle, o_fifo_cnt=0, o_wr_ptr=ADR_LL.
